// File: rtl/xif_copro_issue_ctrl_if.sv
// Bundle of issue, commit, input-buffer, unit and writeback signals around
// xif_copro_issue_ctrl. The slave modport is the controller's view.
interface xif_copro_issue_ctrl_if #(
    parameter int NUM_RS    = 2,
    parameter int NUM_UNITS = 2,
    parameter int ID_WIDTH  = 4
);
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [NUM_RS-1:0]      prd_use_gprs_i;
    logic [NUM_RS-1:0]      issue_rs_valid_i;
    logic                   issue_ready_o;
    logic                   commit_valid_i;
    logic                   commit_kill_i;
    logic [ID_WIDTH-1:0]    commit_id_i;
    logic                   ibuf_push_ready_i;
    logic                   ibuf_pop_valid_i;
    logic                   ibuf_pop_ready_o;
    logic [ID_WIDTH-1:0]    head_id_i;
    logic [UW-1:0]          head_unit_i;
    logic [NUM_RS*5-1:0]    head_rs_i;
    logic [NUM_RS-1:0]      head_rs_copro_i;
    logic [4:0]             head_rd_i;
    logic                   head_rd_copro_i;
    logic [NUM_UNITS-1:0]   unit_in_valid_o;
    logic [NUM_UNITS-1:0]   unit_in_ready_i;
    logic [NUM_UNITS-1:0]   unit_out_valid_i;
    logic [NUM_UNITS-1:0]   unit_out_ready_o;
    logic [NUM_UNITS*5-1:0] unit_out_rd_i;
    logic [NUM_UNITS-1:0]   unit_out_rd_copro_i;
    logic [UW-1:0]          wb_sel_o;
    logic                   result_valid_o;
    logic                   result_ready_i;
    logic                   copreg_we_o;
    logic [4:0]             copreg_waddr_o;
    logic [NUM_RS-1:0]      fwd_o;
    logic                   drain_o;

    modport slave (
        input  prd_use_gprs_i, issue_rs_valid_i, commit_valid_i, commit_kill_i,
               commit_id_i, ibuf_push_ready_i, ibuf_pop_valid_i, head_id_i,
               head_unit_i, head_rs_i, head_rs_copro_i, head_rd_i, head_rd_copro_i,
               unit_in_ready_i, unit_out_valid_i, unit_out_rd_i, unit_out_rd_copro_i,
               result_ready_i,
        output issue_ready_o, ibuf_pop_ready_o, unit_in_valid_o, unit_out_ready_o,
               wb_sel_o, result_valid_o, copreg_we_o, copreg_waddr_o, fwd_o, drain_o
    );

    modport master (
        output prd_use_gprs_i, issue_rs_valid_i, commit_valid_i, commit_kill_i,
               commit_id_i, ibuf_push_ready_i, ibuf_pop_valid_i, head_id_i,
               head_unit_i, head_rs_i, head_rs_copro_i, head_rd_i, head_rd_copro_i,
               unit_in_ready_i, unit_out_valid_i, unit_out_rd_i, unit_out_rd_copro_i,
               result_ready_i,
        input  issue_ready_o, ibuf_pop_ready_o, unit_in_valid_o, unit_out_ready_o,
               wb_sel_o, result_valid_o, copreg_we_o, copreg_waddr_o, fwd_o, drain_o
    );
endinterface

// File: rtl/xif_copro_issue_ctrl.sv
// Multi-unit issue/writeback controller for the XIF coprocessor: commit/kill
// scoreboard, register hazards, per-unit occupancy and round-robin writeback.
// Optional writeback-to-dispatch forwarding: define XIF_COPRO_FORWARD_EN.
// Handshakes: a transfer happens in a cycle where valid and ready are both 1;
// a producer holds valid (and its payload) until that cycle.
module xif_copro_issue_ctrl #(
    parameter int NUM_RS       = 2,
    parameter int NUM_UNITS    = 2,
    parameter int ID_WIDTH     = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    xif_copro_issue_ctrl_if.slave xif
);
    localparam int UW      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int NUM_IDS = 1 << ID_WIDTH;

    logic [NUM_IDS-1:0]   r_committed;
    logic [NUM_IDS-1:0]   r_killed;
    logic [31:0]          r_rd_busy;
    logic [3:0]           r_inflight [NUM_UNITS];
    logic [UW-1:0]        r_rr_ptr;

    logic                 w_commit_hit;
    logic                 w_head_committed;
    logic                 w_head_killed;
    logic                 w_drain;
    logic                 w_any_valid;
    logic [UW-1:0]        w_grant;
    logic [4:0]           w_wb_rd;
    logic                 w_wb_copro;
    logic                 w_wb_hs;
    logic                 w_copreg_we;
    logic [4:0]           w_copreg_waddr;
    logic [NUM_RS-1:0]    w_fwd;
    logic                 w_raw;
    logic                 w_waw;
    logic                 w_unit_ok;
    logic [3:0]           w_head_inflight;
    logic                 w_disp_ok;
    logic [NUM_UNITS-1:0] w_unit_in_valid;
    logic                 w_disp_hs;

    assign xif.issue_ready_o = (&(~xif.prd_use_gprs_i | xif.issue_rs_valid_i))
                               & xif.ibuf_push_ready_i;

    // A commit arriving in the same cycle as its head entry is honoured at once.
    assign w_commit_hit     = xif.commit_valid_i && (xif.commit_id_i == xif.head_id_i);
    assign w_head_committed = r_committed[xif.head_id_i] | (w_commit_hit & ~xif.commit_kill_i);
    assign w_head_killed    = r_killed[xif.head_id_i]    | (w_commit_hit &  xif.commit_kill_i);
    assign w_drain          = xif.ibuf_pop_valid_i & w_head_killed;

    // Round-robin search starting at the pointer; the grant only moves on a handshake.
    always_comb begin
        int  idx;
        logic found;
        w_grant    = '0;
        w_wb_rd    = '0;
        w_wb_copro = 1'b0;
        found      = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
            if (!found && xif.unit_out_valid_i[idx]) begin
                w_grant = UW'(idx);
                found   = 1'b1;
            end
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (UW'(u) == w_grant) begin
                w_wb_rd    = xif.unit_out_rd_i[u*5 +: 5];
                w_wb_copro = xif.unit_out_rd_copro_i[u];
            end
        end
    end

    assign w_any_valid    = |xif.unit_out_valid_i;
    assign w_wb_hs        = w_any_valid & xif.result_ready_i;
    assign w_copreg_we    = w_wb_hs & w_wb_copro;
    assign w_copreg_waddr = w_wb_hs ? w_wb_rd : 5'd0;

    assign xif.wb_sel_o         = w_grant;
    assign xif.result_valid_o   = w_any_valid;
    assign xif.unit_out_ready_o = w_wb_hs ? (NUM_UNITS'(1) << w_grant) : '0;
    assign xif.copreg_we_o      = w_copreg_we;
    assign xif.copreg_waddr_o   = w_copreg_waddr;

    always_comb begin
        w_fwd = '0;
        w_raw = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
`ifdef XIF_COPRO_FORWARD_EN
            w_fwd[i] = w_copreg_we & xif.head_rs_copro_i[i]
                       & (xif.head_rs_i[i*5 +: 5] == w_copreg_waddr);
`else
            w_fwd[i] = 1'b0;
`endif
            if (xif.head_rs_copro_i[i] && r_rd_busy[xif.head_rs_i[i*5 +: 5]] && !w_fwd[i])
                w_raw = 1'b1;
        end
    end

    assign xif.fwd_o = w_fwd;

    // A writer of the same rd retiring this cycle releases the WAW stall.
    assign w_waw = xif.head_rd_copro_i & r_rd_busy[xif.head_rd_i]
                   & ~(w_copreg_we && (w_copreg_waddr == xif.head_rd_i));

    always_comb begin
        w_unit_ok       = 1'b0;
        w_head_inflight = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (UW'(u) == xif.head_unit_i) begin
                w_unit_ok       = 1'b1;
                w_head_inflight = r_inflight[u];
            end
        end
    end

    assign w_disp_ok = xif.ibuf_pop_valid_i & ~w_drain & w_head_committed & ~w_head_killed
                       & ~w_raw & ~w_waw & w_unit_ok
                       & (w_head_inflight < 4'(MAX_INFLIGHT));

    always_comb begin
        w_unit_in_valid = '0;
        for (int u = 0; u < NUM_UNITS; u++)
            w_unit_in_valid[u] = w_disp_ok && (UW'(u) == xif.head_unit_i);
    end

    assign w_disp_hs            = |(w_unit_in_valid & xif.unit_in_ready_i);
    assign xif.unit_in_valid_o  = w_unit_in_valid;
    assign xif.ibuf_pop_ready_o = w_drain | w_disp_hs;
    assign xif.drain_o          = w_drain;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_committed <= '0;
            r_killed    <= '0;
            r_rd_busy   <= '0;
            r_rr_ptr    <= '0;
            for (int u = 0; u < NUM_UNITS; u++) r_inflight[u] <= '0;
        end else begin
            // A fresh commit on an ID overrides whatever state the ID held.
            if (xif.commit_valid_i) begin
                r_committed[xif.commit_id_i] <= ~xif.commit_kill_i;
                r_killed[xif.commit_id_i]    <=  xif.commit_kill_i;
            end
            if (w_disp_hs) r_committed[xif.head_id_i] <= 1'b0;
            if (w_drain)   r_killed[xif.head_id_i]    <= 1'b0;

            // Ordered so that a new writer's set beats a retiring writer's clear.
            if (w_copreg_we) r_rd_busy[w_copreg_waddr] <= 1'b0;
            if (w_disp_hs && xif.head_rd_copro_i) r_rd_busy[xif.head_rd_i] <= 1'b1;

            if (w_wb_hs)
                r_rr_ptr <= (int'(w_grant) == NUM_UNITS - 1) ? '0 : w_grant + 1'b1;

            for (int u = 0; u < NUM_UNITS; u++) begin
                if (w_disp_hs && (UW'(u) == xif.head_unit_i) && !(w_wb_hs && (UW'(u) == w_grant)))
                    r_inflight[u] <= r_inflight[u] + 4'd1;
                else if (w_wb_hs && (UW'(u) == w_grant) && !(w_disp_hs && (UW'(u) == xif.head_unit_i)))
                    r_inflight[u] <= r_inflight[u] - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_xif_copro_issue_ctrl.sv
// Directed bench for xif_copro_issue_ctrl; expectations for forwarding follow
// XIF_COPRO_FORWARD_EN so the same file covers both builds.
module tb_xif_copro_issue_ctrl;
    localparam int NUM_RS       = 2;
    localparam int NUM_UNITS    = 2;
    localparam int ID_WIDTH     = 4;
    localparam int MAX_INFLIGHT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xif_copro_issue_ctrl_if #(.NUM_RS(NUM_RS), .NUM_UNITS(NUM_UNITS), .ID_WIDTH(ID_WIDTH)) xif ();

    xif_copro_issue_ctrl #(
        .NUM_RS(NUM_RS), .NUM_UNITS(NUM_UNITS), .ID_WIDTH(ID_WIDTH), .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .xif   (xif)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        xif.prd_use_gprs_i      = '0;
        xif.issue_rs_valid_i    = '0;
        xif.commit_valid_i      = 1'b0;
        xif.commit_kill_i       = 1'b0;
        xif.commit_id_i         = '0;
        xif.ibuf_push_ready_i   = 1'b1;
        xif.ibuf_pop_valid_i    = 1'b0;
        xif.head_id_i           = '0;
        xif.head_unit_i         = '0;
        xif.head_rs_i           = '0;
        xif.head_rs_copro_i     = '0;
        xif.head_rd_i           = '0;
        xif.head_rd_copro_i     = 1'b0;
        xif.unit_in_ready_i     = 2'b11;
        xif.unit_out_valid_i    = '0;
        xif.unit_out_rd_i       = '0;
        xif.unit_out_rd_copro_i = '0;
        xif.result_ready_i      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic set_head(input logic v, input logic [3:0] id, input logic unit,
                            input logic [4:0] rs0, input logic rs0_copro,
                            input logic [4:0] rd, input logic rd_copro);
        xif.ibuf_pop_valid_i = v;
        xif.head_id_i        = id;
        xif.head_unit_i      = unit;
        xif.head_rs_i        = {5'd0, rs0};
        xif.head_rs_copro_i  = {1'b0, rs0_copro};
        xif.head_rd_i        = rd;
        xif.head_rd_copro_i  = rd_copro;
    endtask

    task automatic commit(input logic v, input logic [3:0] id, input logic kill);
        xif.commit_valid_i = v;
        xif.commit_id_i    = id;
        xif.commit_kill_i  = kill;
    endtask

    task automatic unit_out(input logic [1:0] v, input logic [4:0] rd0, input logic [4:0] rd1,
                            input logic [1:0] copro);
        xif.unit_out_valid_i    = v;
        xif.unit_out_rd_i       = {rd1, rd0};
        xif.unit_out_rd_copro_i = copro;
    endtask

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        logic [7:0] e;

        // Outputs during reset
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        #1;
        check("rst_pop", 32'(xif.ibuf_pop_ready_o), 32'd0);
        check("rst_uiv", 32'(xif.unit_in_valid_o), 32'd0);
        check("rst_uor", 32'(xif.unit_out_ready_o), 32'd0);
        check("rst_rv", 32'(xif.result_valid_o), 32'd0);
        check("rst_we", 32'(xif.copreg_we_o), 32'd0);
        check("rst_drain", 32'(xif.drain_o), 32'd0);
        check("rst_issue_rdy", 32'(xif.issue_ready_o), 32'd1);
        rst = 1'b0;
        cyc();

        // issue_ready combinational
        xif.prd_use_gprs_i = 2'b01; xif.issue_rs_valid_i = 2'b00; #1;
        check("issue_rdy_missing_rs", 32'(xif.issue_ready_o), 32'd0);
        xif.issue_rs_valid_i = 2'b01; #1;
        check("issue_rdy_rs_ok", 32'(xif.issue_ready_o), 32'd1);
        xif.ibuf_push_ready_i = 1'b0; #1;
        check("issue_rdy_buf_full", 32'(xif.issue_ready_o), 32'd0);
        idle_inputs();
        cyc();

        // Uncommitted head waits; same-cycle commit dispatches it
        set_head(1'b1, 4'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        check("uncommitted_uiv", 32'(xif.unit_in_valid_o), 32'd0);
        check("uncommitted_pop", 32'(xif.ibuf_pop_ready_o), 32'd0);
        cyc();
        commit(1'b1, 4'd3, 1'b0); #1;
        check("commit_byp_uiv", 32'(xif.unit_in_valid_o), 32'd1);
        check("commit_byp_pop", 32'(xif.ibuf_pop_ready_o), 32'd1);
        cyc();
        commit(1'b0, 4'd0, 1'b0); #1;
        check("committed_cleared", 32'(xif.unit_in_valid_o), 32'd0);
        xif.ibuf_pop_valid_i = 1'b0;
        unit_out(2'b01, 5'd0, 5'd0, 2'b00);
        xif.result_ready_i = 1'b1; #1;
        check("wb1_rv", 32'(xif.result_valid_o), 32'd1);
        check("wb1_sel", 32'(xif.wb_sel_o), 32'd0);
        check("wb1_uor", 32'(xif.unit_out_ready_o), 32'd1);
        check("wb1_we", 32'(xif.copreg_we_o), 32'd0);
        cyc();
        unit_out(2'b00, 5'd0, 5'd0, 2'b00);

        // Kill drains the head
        set_head(1'b1, 4'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        commit(1'b1, 4'd5, 1'b1); #1;
        check("kill_drain", 32'(xif.drain_o), 32'd1);
        check("kill_pop", 32'(xif.ibuf_pop_ready_o), 32'd1);
        check("kill_uiv", 32'(xif.unit_in_valid_o), 32'd0);
        check("kill_rv", 32'(xif.result_valid_o), 32'd0);
        cyc();
        commit(1'b0, 4'd0, 1'b0); #1;
        check("killed_cleared_drain", 32'(xif.drain_o), 32'd0);
        check("killed_cleared_pop", 32'(xif.ibuf_pop_ready_o), 32'd0);
        xif.ibuf_pop_valid_i = 1'b0;
        cyc();

        // In-flight limit on unit 0
        for (int k = 1; k <= 4; k++) begin
            set_head(1'b1, 4'(k), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
            commit(1'b1, 4'(k), 1'b0); #1;
            check($sformatf("inflight_disp%0d", k), 32'(xif.unit_in_valid_o), 32'd1);
            cyc();
        end
        set_head(1'b1, 4'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        commit(1'b1, 4'd5, 1'b0); #1;
        check("inflight_full_stall", 32'(xif.unit_in_valid_o), 32'd0);
        cyc();
        commit(1'b0, 4'd0, 1'b0);
        unit_out(2'b01, 5'd0, 5'd0, 2'b00); #1;
        check("inflight_stall_in_wb", 32'(xif.unit_in_valid_o), 32'd0);
        check("inflight_wb_uor", 32'(xif.unit_out_ready_o), 32'd1);
        cyc();
        unit_out(2'b00, 5'd0, 5'd0, 2'b00); #1;
        check("inflight_resume_uiv", 32'(xif.unit_in_valid_o), 32'd1);
        check("inflight_resume_pop", 32'(xif.ibuf_pop_ready_o), 32'd1);
        cyc();
        xif.ibuf_pop_valid_i = 1'b0;
        unit_out(2'b01, 5'd0, 5'd0, 2'b00);
        for (int k = 0; k < 4; k++) cyc();
        unit_out(2'b00, 5'd0, 5'd0, 2'b00);

        // Round-robin grants, then hold while result not ready
        do_reset();
        exp_q = {8'd0, 8'd1, 8'd0, 8'd1};
        unit_out(2'b11, 5'd0, 5'd0, 2'b00);
        xif.result_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            e = exp_q.pop_front();
            check($sformatf("rr_sel%0d", k), 32'(xif.wb_sel_o), 32'(e));
            check($sformatf("rr_uor%0d", k), 32'(xif.unit_out_ready_o), 32'(2'b01 << e[0]));
            cyc();
        end
        xif.result_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("rr_hold_sel%0d", k), 32'(xif.wb_sel_o), 32'd0);
            check($sformatf("rr_hold_uor%0d", k), 32'(xif.unit_out_ready_o), 32'd0);
            check($sformatf("rr_hold_rv%0d", k), 32'(xif.result_valid_o), 32'd1);
            cyc();
        end

        // RAW on x7 resolved by writeback
        do_reset();
        set_head(1'b1, 4'd6, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        commit(1'b1, 4'd6, 1'b0); #1;
        check("raw_writer_disp", 32'(xif.unit_in_valid_o), 32'd1);
        cyc();
        set_head(1'b1, 4'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
        commit(1'b1, 4'd7, 1'b0); #1;
        check("raw_stall", 32'(xif.unit_in_valid_o), 32'd0);
        cyc();
        commit(1'b0, 4'd0, 1'b0);
        unit_out(2'b01, 5'd7, 5'd0, 2'b01);
        xif.result_ready_i = 1'b1; #1;
        check("raw_wb_we", 32'(xif.copreg_we_o), 32'd1);
        check("raw_wb_waddr", 32'(xif.copreg_waddr_o), 32'd7);
`ifdef XIF_COPRO_FORWARD_EN
        check("raw_fwd_uiv", 32'(xif.unit_in_valid_o), 32'd2);
        check("raw_fwd_fwd", 32'(xif.fwd_o), 32'd1);
        cyc();
        unit_out(2'b00, 5'd0, 5'd0, 2'b00);
        xif.ibuf_pop_valid_i = 1'b0;
`else
        check("raw_nofwd_uiv", 32'(xif.unit_in_valid_o), 32'd0);
        check("raw_nofwd_fwd", 32'(xif.fwd_o), 32'd0);
        cyc();
        unit_out(2'b00, 5'd0, 5'd0, 2'b00); #1;
        check("raw_late_uiv", 32'(xif.unit_in_valid_o), 32'd2);
        check("raw_late_fwd", 32'(xif.fwd_o), 32'd0);
`endif
        cyc();

        // WAW on x9: retire and new writer in the same cycle keep x9 busy
        do_reset();
        set_head(1'b1, 4'd8, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        commit(1'b1, 4'd8, 1'b0); #1;
        check("waw_first_disp", 32'(xif.unit_in_valid_o), 32'd1);
        cyc();
        set_head(1'b1, 4'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1);
        commit(1'b1, 4'd9, 1'b0); #1;
        check("waw_stall", 32'(xif.unit_in_valid_o), 32'd0);
        cyc();
        commit(1'b0, 4'd0, 1'b0);
        unit_out(2'b01, 5'd9, 5'd0, 2'b01);
        xif.result_ready_i = 1'b1; #1;
        check("waw_release_uiv", 32'(xif.unit_in_valid_o), 32'd2);
        check("waw_release_we", 32'(xif.copreg_we_o), 32'd1);
        check("waw_release_waddr", 32'(xif.copreg_waddr_o), 32'd9);
        cyc();
        unit_out(2'b00, 5'd0, 5'd0, 2'b00);
        set_head(1'b1, 4'd10, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
        commit(1'b1, 4'd10, 1'b0); #1;
        check("x9_still_busy", 32'(xif.unit_in_valid_o), 32'd0);
        check("x9_no_fwd", 32'(xif.fwd_o), 32'd0);
        cyc();
        idle_inputs();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
